// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths and types for the register write-back arbiter.
package reg_wb_arbiter_pkg;

  localparam int WB_ADDR_W    = 5;
  localparam int WB_DATA_W    = 32;
  localparam int WB_REG_NUM   = 32;
  localparam int WB_BUF_DEPTH = 2;

  // mem wins this many times in a row before a waiting ex entry is forced out
  localparam logic [1:0] WB_STARV_MAX = 2'd2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EX,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// Sync FIFO of {addr,data} with full/empty flags and per-entry addr/valid taps.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AW-1:0]     push_addr,
  input  logic [DW-1:0]     push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AW-1:0]     head_addr,
  output logic [DW-1:0]     head_data,
  output logic [DEPTH-1:0]  tap_valid,
  output logic [DEPTH*AW-1:0] tap_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

  assign head_addr = addr_q[rd_q[PW-1:0]];
  assign head_data = data_q[rd_q[PW-1:0]];
  assign tap_valid = vld_q;

  always_comb begin
    tap_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tap_addr[i*AW +: AW] = addr_q[i];
    end
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      vld_d[rd_q[PW-1:0]] = 1'b0;
      rd_d = rd_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_q[PW-1:0]]  = 1'b1;
      addr_d[wr_q[PW-1:0]] = push_addr;
      data_d[wr_q[PW-1:0]] = push_data;
      wr_d = wr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      vld_q  <= '0;
      addr_q <= '{default: '0};
      data_q <= '{default: '0};
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges ex and mem result streams onto the register-file write port.
// Define WB_PERF_CNT_EN to add the wb_cnt/stall_cnt performance counters.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W    = WB_ADDR_W,
  parameter int DATA_W    = WB_DATA_W,
  parameter int BUF_DEPTH = WB_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_request,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       wb_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic                      ex_full, ex_empty, ex_push, ex_pop;
  logic                      mem_full, mem_empty, mem_push, mem_pop;
  logic [ADDR_W-1:0]         ex_head_addr, mem_head_addr;
  logic [DATA_W-1:0]         ex_head_data, mem_head_data;
  logic [BUF_DEPTH-1:0]      ex_tap_valid, mem_tap_valid;
  logic [BUF_DEPTH*ADDR_W-1:0] ex_tap_addr, mem_tap_addr;

  wb_src_e           src;
  logic              ex_first, mem_go, hit;
  logic [1:0]        starv_q, starv_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;

  assign ex_ready  = rst & ~ex_full;
  assign mem_ready = rst & ~mem_full;
  // r0 writes complete the handshake but never reach the FIFO
  assign ex_push   = ex_valid & ex_ready & (|ex_addr);
  assign mem_push  = mem_valid & mem_ready & (|mem_addr);
  assign ex_pop    = (src == SRC_EX);
  assign mem_pop   = (src == SRC_MEM);

  wb_fifo #(.DEPTH(BUF_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_ex_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ex_push),
    .push_addr (ex_addr),
    .push_data (ex_data),
    .pop       (ex_pop),
    .full      (ex_full),
    .empty     (ex_empty),
    .head_addr (ex_head_addr),
    .head_data (ex_head_data),
    .tap_valid (ex_tap_valid),
    .tap_addr  (ex_tap_addr)
  );

  wb_fifo #(.DEPTH(BUF_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (mem_pop),
    .full      (mem_full),
    .empty     (mem_empty),
    .head_addr (mem_head_addr),
    .head_data (mem_head_data),
    .tap_valid (mem_tap_valid),
    .tap_addr  (mem_tap_addr)
  );

  assign ex_first = ~ex_empty & (mem_empty | (starv_q == WB_STARV_MAX));
  assign mem_go   = ~mem_empty & ~ex_first;

  always_comb begin
    src      = SRC_NONE;
    wr_d     = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    unique case (1'b1)
      ex_first: begin
        src      = SRC_EX;
        wr_d     = 1'b1;
        w_addr_d = ex_head_addr;
        w_data_d = ex_head_data;
      end
      mem_go: begin
        src      = SRC_MEM;
        wr_d     = 1'b1;
        w_addr_d = mem_head_addr;
        w_data_d = mem_head_data;
      end
      default: ;
    endcase
    starv_d = (mem_go & ~ex_empty) ? starv_q + 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starv_q  <= '0;
      wr_q     <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      starv_q  <= starv_d;
      wr_q     <= wr_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign write_request = wr_q;
  assign w_addr        = w_addr_q;
  assign w_data        = w_data_q;

  always_comb begin
    hit = wr_q & (w_addr_q == q_addr);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      hit = hit |
            (ex_tap_valid[i] & (ex_tap_addr[i*ADDR_W +: ADDR_W] == q_addr)) |
            (mem_tap_valid[i] & (mem_tap_addr[i*ADDR_W +: ADDR_W] == q_addr));
    end
    q_pending = (|q_addr) & hit;
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] wb_cnt_q, wb_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    wb_cnt_d    = wb_cnt_q + {31'd0, wr_q};
    stall_cnt_d = stall_cnt_q +
                  {31'd0, (ex_valid & ~ex_ready) | (mem_valid & ~mem_ready)};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_cnt_q    <= wb_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_cnt    = wb_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed spec scenarios plus randomized traffic.
module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid = 1'b0, mem_valid = 1'b0;
  logic [AW-1:0] ex_addr = '0, mem_addr = '0, q_addr = '0;
  logic [DW-1:0] ex_data = '0, mem_data = '0;
  logic          ex_ready, mem_ready, write_request, q_pending;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0]   wb_cnt, stall_cnt;
`endif

  int errs = 0;
  int checks = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_addr       (ex_addr),
    .ex_data       (ex_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .write_request (write_request),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .q_addr        (q_addr),
    .q_pending     (q_pending)
`ifdef WB_PERF_CNT_EN
    ,
    .wb_cnt        (wb_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: per-source queues and the write port as seen after each edge
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          exq[$];
  ent_t          memq[$];
  int            ex_waits = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  logic [31:0]   m_wb_cnt = '0;
  logic [31:0]   m_stall = '0;

  function automatic bit m_pend(input logic [AW-1:0] qa);
    if (qa == 0) return 1'b0;
    foreach (exq[i]) if (exq[i].a == qa) return 1'b1;
    foreach (memq[i]) if (memq[i].a == qa) return 1'b1;
    return m_wr && (m_wa == qa);
  endfunction

  task automatic m_step();
    bit   ex_acc, mem_acc;
    ent_t e;
    if (!rst) begin
      exq.delete();
      memq.delete();
      ex_waits = 0;
      m_wr = 1'b0;
      m_wa = '0;
      m_wd = '0;
      m_wb_cnt = '0;
      m_stall = '0;
      return;
    end
    ex_acc  = ex_valid && (exq.size() < D);
    mem_acc = mem_valid && (memq.size() < D);
    m_wb_cnt = m_wb_cnt + {31'd0, m_wr};
    if ((ex_valid && !ex_acc) || (mem_valid && !mem_acc))
      m_stall = m_stall + 32'd1;
    m_wr = 1'b0;
    if (memq.size() > 0 && !(ex_waits == 2 && exq.size() > 0)) begin
      e = memq.pop_front();
      m_wr = 1'b1; m_wa = e.a; m_wd = e.d;
      ex_waits = (exq.size() > 0) ? ex_waits + 1 : 0;
    end else if (exq.size() > 0) begin
      e = exq.pop_front();
      m_wr = 1'b1; m_wa = e.a; m_wd = e.d;
      ex_waits = 0;
    end else begin
      ex_waits = 0;
    end
    if (ex_acc && ex_addr != 0) exq.push_back('{ex_addr, ex_data});
    if (mem_acc && mem_addr != 0) memq.push_back('{mem_addr, mem_data});
  endtask

  // Inputs change just after posedge; compare then advance the model at negedge
  initial begin
    forever begin
      @(negedge clk);
      if (en) begin
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, rst && exq.size() < D});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, rst && memq.size() < D});
        chk("write_request", {31'd0, write_request}, {31'd0, m_wr});
        chk("w_addr", {27'd0, w_addr}, {27'd0, m_wa});
        chk("w_data", w_data, m_wd);
        chk("q_pending", {31'd0, q_pending}, {31'd0, m_pend(q_addr)});
`ifdef WB_PERF_CNT_EN
        chk("wb_cnt", wb_cnt, m_wb_cnt);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
      end
      m_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    step();
    step();
    en = 1'b1;
    chk("rst_wr", {31'd0, write_request}, 32'd0);
    chk("rst_waddr", {27'd0, w_addr}, 32'd0);
    chk("rst_wdata", w_data, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    rst = 1'b1;

    // single ex write, two-cycle latency
    ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'h11;
    step();
    idle();
    chk("t1_wr_early", {31'd0, write_request}, 32'd0);
    step();
    chk("t1_wr", {31'd0, write_request}, 32'd1);
    chk("t1_waddr", {27'd0, w_addr}, 32'd5);
    chk("t1_wdata", w_data, 32'h11);
    step();
    chk("t1_wr_off", {31'd0, write_request}, 32'd0);

    // simultaneous ex and mem, mem first
    ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 32'hA;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hB;
    step();
    idle();
    step();
    chk("t2_first", {27'd0, w_addr}, 32'd2);
    chk("t2_first_d", w_data, 32'hB);
    step();
    chk("t2_second", {27'd0, w_addr}, 32'd1);
    chk("t2_second_d", w_data, 32'hA);
    step();

    // continuous mem traffic, ex r3 forced out on the 3rd arbitration
    ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 32'h33;
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h90;
    step();
    ex_valid = 1'b0;
    step();
    chk("t3_arb1", {27'd0, w_addr}, 32'd9);
    step();
    chk("t3_arb2", {27'd0, w_addr}, 32'd9);
    step();
    chk("t3_arb3", {27'd0, w_addr}, 32'd3);
    chk("t3_arb3_d", w_data, 32'h33);
    drain(6);

    // fill ex FIFO behind mem traffic, then one pop frees a slot
    ex_valid = 1'b1; ex_addr = 5'd4; ex_data = 32'h44;
    mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h88;
    step();
    step();
    chk("t4_full1", {31'd0, ex_ready}, 32'd0);
    step();
    chk("t4_full2", {31'd0, ex_ready}, 32'd0);
    step();
    chk("t4_freed", {31'd0, ex_ready}, 32'd1);
    chk("t4_pop", {27'd0, w_addr}, 32'd4);
    drain(8);

    // r0 write is accepted and dropped
    ex_valid = 1'b1; ex_addr = 5'd0; ex_data = 32'hDEAD; q_addr = 5'd0;
    #1;
    chk("t5_ready", {31'd0, ex_ready}, 32'd1);
    step();
    idle();
    chk("t5_qpend", {31'd0, q_pending}, 32'd0);
    step();
    chk("t5_nowr1", {31'd0, write_request}, 32'd0);
    step();
    chk("t5_nowr2", {31'd0, write_request}, 32'd0);

    // pending query tracks r7 until its write cycle ends
    ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'h77; q_addr = 5'd7;
    #1;
    chk("t6_pend_pre", {31'd0, q_pending}, 32'd0);
    step();
    idle();
    chk("t6_pend_q", {31'd0, q_pending}, 32'd1);
    step();
    chk("t6_pend_wr", {31'd0, q_pending}, 32'd1);
    chk("t6_wr", {31'd0, write_request}, 32'd1);
    step();
    chk("t6_pend_done", {31'd0, q_pending}, 32'd0);

    // reset with entries queued
    ex_valid = 1'b1; ex_addr = 5'd6; ex_data = 32'h66;
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h55;
    step();
    ex_addr = 5'd10; mem_addr = 5'd11;
    step();
    idle();
    rst = 1'b0; q_addr = 5'd6;
    step();
    chk("t6_rst_wr", {31'd0, write_request}, 32'd0);
    chk("t6_rst_waddr", {27'd0, w_addr}, 32'd0);
    chk("t6_rst_wdata", w_data, 32'd0);
    chk("t6_rst_pend", {31'd0, q_pending}, 32'd0);
`ifdef WB_PERF_CNT_EN
    chk("t6_rst_wbcnt", wb_cnt, 32'd0);
    chk("t6_rst_stall", stall_cnt, 32'd0);
`endif
    rst = 1'b1;
    step();
    chk("t6_post1", {31'd0, write_request}, 32'd0);
    step();
    chk("t6_post2", {31'd0, write_request}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 149) != 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      mem_valid = ($urandom_range(0, 2) != 0);
      ex_addr   = AW'($urandom_range(0, 7));
      mem_addr  = AW'($urandom_range(0, 7));
      ex_data   = $urandom;
      mem_data  = $urandom;
      q_addr    = AW'($urandom_range(0, 7));
      step();
    end
    rst = 1'b1;
    drain(10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
